// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per consumed beat, with last flag and optional even parity.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             par;
  logic             out_bit;
  logic             final_bit;
  logic             consume;
  logic             accept;

  assign out_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign shifted   = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign final_bit = (state == PAR) || (state == SHIFT && cnt == '0 && PARITY_EN == 0);

  assign sout_valid = (state != IDLE);
  assign busy       = (state != IDLE);
  assign last       = final_bit;
  assign sout       = (state == SHIFT) ? out_bit : (state == PAR) ? par : 1'b0;
  assign consume    = sout_valid && sout_ready;
  // Ready during the consumed final beat lets the next frame start with no bubble.
  assign load_ready = !reset && ((state == IDLE) || (final_bit && sout_ready));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= din;
      cnt   <= CW'(WIDTH - 1);
      par   <= ^din;
    end else if (consume) begin
      case (state)
        SHIFT: begin
          shreg <= shifted;
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= (PARITY_EN != 0) ? PAR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked every cycle against a
// bit-sequence model, plus directed literal expectations and a SIPO rebuild.
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din [3];
  logic [2:0] lv = '0;
  logic [2:0] sr = 3'b111;
  wire  [2:0] lr, so, sv, la, bz;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(reset), .din(din[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .sout_ready(sr[0]), .last(la[0]), .busy(bz[0]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .din(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .sout_ready(sr[1]), .last(la[1]), .busy(bz[1]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .din(din[2]), .load_valid(lv[2]), .load_ready(lr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .sout_ready(sr[2]), .last(la[2]), .busy(bz[2]));

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Model: each instance holds the remaining bit sequence of its current frame.
  bit         seq [3][5];
  int         rem [3];
  int         pos [3];
  bit         chk_en = 1'b0;
  logic [3:0] accq [$];
  int         acc_total = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin rem[k] = 0; pos[k] = 0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit elr;
        elr = (rem[k] == 0) || (rem[k] == 1 && sr[k]);
        if (rem[k] > 0 && sr[k]) begin rem[k]--; pos[k]++; end
        if (lv[k] && elr) begin
          for (int i = 0; i < 4; i++) seq[k][i] = (k != 2) ? din[k][3-i] : din[k][i];
          seq[k][4] = ^din[k];
          pos[k] = 0;
          rem[k] = (k == 1) ? 5 : 4;
          if (k == 2) begin accq.push_back(din[2]); acc_total++; end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic es;
        es = (rem[k] > 0) ? seq[k][pos[k]] : 1'b0;
        chk($sformatf("u%0d_sout t=%0t", k, $time), 16'(so[k]), 16'(es));
        chk($sformatf("u%0d_valid t=%0t", k, $time), 16'(sv[k]), 16'(rem[k] > 0));
        chk($sformatf("u%0d_busy t=%0t", k, $time), 16'(bz[k]), 16'(rem[k] > 0));
        chk($sformatf("u%0d_last t=%0t", k, $time), 16'(la[k]), 16'(rem[k] == 1));
        chk($sformatf("u%0d_ready t=%0t", k, $time), 16'(lr[k]),
            16'(!reset && (rem[k] == 0 || (rem[k] == 1 && sr[k]))));
      end
    end
  end

  // SIPO rebuild of the LSB-first instance, compared against accepted words.
  logic [3:0] sw = '0;
  int         nb = 0;
  int         rebuilt = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en && !reset && sv[2] && sr[2]) begin
      sw[nb] = so[2];
      nb++;
      if (nb == 4) begin
        nb = 0;
        rebuilt++;
        if (accq.size() > 0) chk("sipo_word", 16'(sw), 16'(accq.pop_front()));
        else begin
          tests++; fails++;
          $display("FAIL sipo_word got=%h exp=none", sw);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int k, input logic [3:0] d);
    din[k] = d; lv[k] = 1'b1; sr[k] = 1'b1;
    tick();
    lv[k] = 1'b0;
  endtask

  // Runs n cycles with per-cycle ready/valid patterns (leftmost bit = first cycle);
  // captured outputs are packed the same way.
  task automatic run(input int k, input int n, input logic [15:0] rdy, input logic [15:0] lvp,
                     output logic [15:0] s, output logic [15:0] v, output logic [15:0] l,
                     output logic [15:0] r, output logic [15:0] b);
    s = '0; v = '0; l = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      sr[k] = rdy[n-1-i];
      lv[k] = lvp[n-1-i];
      @(negedge clk);
      s = {s[14:0], so[k]};
      v = {v[14:0], sv[k]};
      l = {l[14:0], la[k]};
      r = {r[14:0], lr[k]};
      b = {b[14:0], bz[k]};
      tick();
    end
    sr[k] = 1'b1;
    lv[k] = 1'b0;
  endtask

  logic [15:0] s, v, l, r, b;

  initial begin
    for (int k = 0; k < 3; k++) din[k] = '0;
    tick(); tick();
    reset = 1'b0;

    // 4'hA MSB first, then idle
    load(0, 4'hA);
    run(0, 5, 16'h1F, 16'h0, s, v, l, r, b);
    chk("t1_sout", s, 16'b10100);
    chk("t1_valid", v, 16'b11110);
    chk("t1_last", l, 16'b00010);
    chk("t1_ready", r, 16'b00011);

    // back-to-back frames with load_valid held
    load(0, 4'hF);
    din[0] = 4'h3;
    run(0, 8, 16'hFF, 16'b11110000, s, v, l, r, b);
    chk("t2_sout", s, 16'b11110011);
    chk("t2_valid", v, 16'hFF);
    chk("t2_ready", r, 16'b00010001);

    // stall two cycles after bit 1
    load(0, 4'h9);
    run(0, 6, 16'b100111, 16'h0, s, v, l, r, b);
    chk("t3_sout", s, 16'b100001);
    chk("t3_valid", v, 16'b111111);
    chk("t3_last", l, 16'b000001);

    // parity trailer
    load(1, 4'h7);
    run(1, 5, 16'h1F, 16'h0, s, v, l, r, b);
    chk("t4_sout7", s, 16'b01111);
    chk("t4_last7", l, 16'b00001);
    load(1, 4'h3);
    run(1, 5, 16'h1F, 16'h0, s, v, l, r, b);
    chk("t4_sout3", s, 16'b00110);
    chk("t4_last3", l, 16'b00001);

    // reset mid-frame, then a clean frame
    load(0, 4'h5);
    run(0, 2, 16'h3, 16'h0, s, v, l, r, b);
    chk("t5_pre", s, 16'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(0, 1, 16'h1, 16'h0, s, v, l, r, b);
    chk("t5_valid", v, 16'b0);
    chk("t5_busy", b, 16'b0);
    chk("t5_ready", r, 16'b1);
    load(0, 4'hC);
    run(0, 4, 16'hF, 16'h0, s, v, l, r, b);
    chk("t5_sout", s, 16'b1100);

    // LSB first, then random words with random stalls
    load(2, 4'hA);
    run(2, 4, 16'hF, 16'h0, s, v, l, r, b);
    chk("t6_sout", s, 16'b0101);
    for (int c = 0; c < 3000 && rebuilt < 31; c++) begin
      lv[2] = (acc_total < 31);
      din[2] = 4'($urandom);
      sr[2] = ($urandom_range(0, 3) != 0);
      tick();
    end
    lv[2] = 1'b0;
    sr[2] = 1'b1;
    chk("t6_words", 16'(rebuilt), 16'd31);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
